rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//  4-requester round-robin arbiter for one shared resource (bus or functional unit).
//  Registers the winner index; a 2-to-4 decoder with active-high enable turns it into one-hot grants.
//  Holds a grant until the owner releases it or a hold-timeout fires.
//  Sits between requesting blocks and the shared datapath.
// PARAMETERS
//  HOLD_MAX  8  max consecutive GRANT cycles per owner; 0 = no timeout; otherwise must be >= 2
//  CNT_W     derived, $clog2(HOLD_MAX)+1; hold-counter width; not user-set
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   4  request vector; req[i] = requester i wants the resource
//  done       in   1  release strobe from the current owner; sampled only in GRANT
//  gnt        out  4  one-hot grant {G3,G2,G1,G0}; 0000 when no owner
//  gnt_id     out  2  index of current owner; holds last owner when gnt_valid=0
//  gnt_valid  out  1  1 while in GRANT; drives the decoder enable
//  timeout    out  1  1-cycle pulse: last grant was ended by HOLD_MAX
// BEHAVIOUR
//  Reset values: state=IDLE, ptr=0, cnt=0, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0.
//  Reset behaviour:
//   - Sampled at every edge and overrides everything, including an active grant.
//   - Outputs read reset values after the edge where rst=1.
//  Outputs: all are registered or decoded from registers; none are combinational from req/done.
//  FSM states: IDLE, GRANT, RELEASE.
//  IDLE / RELEASE (gnt=0000, gnt_valid=0):
//   - Winner = first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
//   - req != 0: next state GRANT, gnt_id <= winner, cnt <= 0.
//   - req == 0: next state IDLE.
//   - Latency: req high at edge N -> gnt valid right after edge N.
//  GRANT (gnt = decode(gnt_id), gnt_valid=1):
//   - Exit when done=1 OR req[gnt_id]=0 OR (HOLD_MAX!=0 AND cnt==HOLD_MAX-1).
//   - On exit: next state RELEASE, ptr <= gnt_id+1 (2-bit wrap: 3 -> 0).
//   - Otherwise: cnt <= cnt+1.
//   - A grant therefore lasts at most HOLD_MAX cycles.
//  RELEASE:
//   - Exactly one turnaround cycle with gnt=0000.
//   - Arbitrates like IDLE, so back-to-back grants have exactly one dead cycle.
//  timeout:
//   - Set to 1 for the RELEASE cycle only when the exit cause was HOLD_MAX.
//   - If done=1 or req[gnt_id]=0 in the same cycle as the limit, the exit is a normal release: timeout=0.
//  Invariants:
//   - Requests from non-owners are ignored during GRANT (no preemption).
//   - gnt is never multi-hot; gnt != 0 iff gnt_valid=1.
// STRUCTURE
//  arb_defs.vh: state encodings (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10) and NREQ=4 localparams.
//  Sub-module grant_decoder: 2-to-4 decoder with active-high enable.
//   - Inputs: E=gnt_valid, A=gnt_id. Output: D=gnt.
//   - Purely combinational from registered signals.
//  Top-level rr_arbiter_4 contains:
//   - FSM
//   - rotating-priority search
//   - ptr register
//   - hold counter
//   - timeout flop
// TESTING
//  1 Reset: rst=1 with req=1111 for 2 cycles.
//    -> gnt=0000, gnt_id=00, gnt_valid=0, timeout=0. First grant after release of rst goes to 0001.
//  2 Single requester: req=0100; done pulsed after 3 grant cycles.
//    -> gnt=0100 and gnt_id=10 one edge after req; 0000 for 1 cycle; then 0100 again.
//  3 Round robin: req=1111 constant; done pulsed each grant cycle.
//    -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
//  4 Wrap and skip: ptr=3 with req=1001.
//    -> grant 1000, then 0001 (wrap). With req=0110 after owner 3 -> 0010.
//  5 Timeout, HOLD_MAX=4: req=0001 held, done=0.
//    -> gnt=0001 for exactly 4 cycles; timeout=1 in the RELEASE cycle; next grant 0001 (sole requester).
//    Repeat with done=1 on the 4th cycle -> timeout=0.
//  6 Reset mid-grant: rst=1 while gnt=0100.
//    -> next edge gnt=0000, ptr=0; with req=1111 after reset the grant is 0001.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
package rr_arbiter_4_pkg;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      GRANT   = 2'b01,
      RELEASE = 2'b10
   } state_e;

   // Rotating-priority search: first set request at ptr, ptr+1, ... (mod NREQ).
   function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [ID_W-1:0] ptr);
      logic [ID_W-1:0] idx;
      logic            found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = ptr + ID_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter_4_grant_decoder.sv
// 2-to-4 decoder with active-high enable; turns the registered owner index into one-hot grants.
module rr_arbiter_4_grant_decoder
   import rr_arbiter_4_pkg::*;
(
   input  logic            en,
   input  logic [ID_W-1:0] a,
   output logic [NREQ-1:0] d
);

   always_comb begin
      d = '0;
      if (en) d[a] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for one shared resource, with per-owner hold timeout and one dead cycle between grants.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter  int HOLD_MAX = 8,
   localparam int CNT_W    = $clog2(HOLD_MAX) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

   state_e           state_q,   state_d;
   logic [ID_W-1:0]  ptr_q,     ptr_d;
   logic [ID_W-1:0]  gnt_id_q,  gnt_id_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             timeout_q, timeout_d;

   logic [ID_W-1:0]  winner;
   logic             hit_limit;
   logic             owner_release;

   assign winner        = rr_pick(req, ptr_q);
   assign hit_limit     = (HOLD_MAX != 0) && (cnt_q == CNT_LIMIT);
   assign owner_release = done || !req[gnt_id_q];

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_id_d  = gnt_id_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE, RELEASE: begin
            if (|req) begin
               state_d  = GRANT;
               gnt_id_d = winner;
               cnt_d    = '0;
            end else begin
               state_d  = IDLE;
            end
         end
         GRANT: begin
            if (owner_release || hit_limit) begin
               state_d   = RELEASE;
               ptr_d     = gnt_id_q + ID_W'(1);
               // A voluntary release in the limit cycle is not reported as a timeout.
               timeout_d = hit_limit && !owner_release;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_id_q  <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_valid = (state_q == GRANT);
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;

   rr_arbiter_4_grant_decoder u_dec (
      .en (gnt_valid),
      .a  (gnt_id_q),
      .d  (gnt)
   );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed, table-driven bench for rr_arbiter_4 (HOLD_MAX=4) with hand sequences for timeout and mid-grant reset.
module tb_rr_arbiter_4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] exp_gnt;
      logic [1:0] exp_id;
      logic       exp_valid;
      logic       exp_to;
   } vec_t;

   vec_t tbl[$];

   rr_arbiter_4 #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic [3:0] rq, logic d,
                               logic [3:0] g, logic [1:0] id, logic v, logic t);
      vec_t x;
      x.rst = r; x.req = rq; x.done = d;
      x.exp_gnt = g; x.exp_id = id; x.exp_valid = v; x.exp_to = t;
      return x;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs, advance one edge, and compare outputs shortly after the edge.
   task automatic run_vec(input vec_t v, input string tag);
      rst = v.rst; req = v.req; done = v.done;
      @(posedge clk);
      #1;
      check({tag, " gnt"},       8'(gnt),       8'(v.exp_gnt));
      check({tag, " gnt_id"},    8'(gnt_id),    8'(v.exp_id));
      check({tag, " gnt_valid"}, 8'(gnt_valid), 8'(v.exp_valid));
      check({tag, " timeout"},   8'(timeout),   8'(v.exp_to));
      check({tag, " onehot"}, 8'(($countones(gnt) <= 1) && ((gnt != 4'b0) == gnt_valid)), 8'd1);
   endtask

   initial begin
      rst = 1'b1; req = 4'b1111; done = 1'b0;

      // reset with all requesting
      tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0));
      // round robin with done each grant cycle
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
      // single requester 2, done after three grant cycles
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
      tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0));
      // owner 2 drops its request -> ptr=3; wrap and skip
      tbl.push_back(mk(0, 4'b1001, 0, 4'b0000, 2'd2, 0, 0));
      tbl.push_back(mk(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 2'd3, 0, 0));
      tbl.push_back(mk(0, 4'b1001, 0, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(0, 4'b0110, 0, 4'b0000, 2'd3, 0, 0));
      tbl.push_back(mk(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0));
      // no preemption by other requesters
      tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0));

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Timeout: ptr=2, sole requester 0 held, no done -> four grant cycles then timeout pulse.
      run_vec(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0), "hold0");
      for (int k = 1; k < 4; k++)
         run_vec(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0), $sformatf("hold%0d", k));
      run_vec(mk(0, 4'b0001, 0, 4'b0000, 2'd0, 0, 1), "to_release");
      run_vec(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0), "to_regrant");

      // Same again but done lands on the fourth cycle: a normal release, no timeout.
      for (int k = 1; k < 4; k++)
         run_vec(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0), $sformatf("hold_d%0d", k));
      run_vec(mk(0, 4'b0001, 1, 4'b0000, 2'd0, 0, 0), "done_at_limit");

      // Reset mid-grant: ptr is 1 here, so a surviving ptr would pick requester 1, not 0.
      run_vec(mk(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0), "pre_rst_grant");
      run_vec(mk(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 0), "mid_rst");
      run_vec(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0), "post_rst_grant");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
